// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared constants, FSM state type and control-byte helper for the ADC scan controller
package adc_scan_pkg;
  localparam int N_CH = 8;
  localparam int FRAME_LEN = 51;
  localparam int CS_LEN = 16;
  localparam logic [1:0] CTRL_PREFIX = 2'b11;
  localparam logic [2:0] CTRL_SUFFIX = 3'b111;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, WAIT} state_t;
  function automatic logic [7:0] ctrl_byte(input logic [2:0] ch);
    return {CTRL_PREFIX, ch, CTRL_SUFFIX};
  endfunction
endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: one ADC frame -- bit counter, chip select, control-bit stream, result shift and capture
//   clk/rst  : clock, synchronous active-high reset
//   clr      : clears bit_cnt and latches ch (asserted by the sequencer in SETUP)
//   run      : frame in progress (XFER or GAP)
//   ch, din  : channel for this frame, serial data from the ADC
//   bit_cnt  : position within the frame; csn/dout : ADC chip select and control stream
//   done     : last clock of the frame; res_valid/res_ch/res_data : captured result, held
module adc_spi_frame #(
  parameter int FRAME_LEN = adc_scan_pkg::FRAME_LEN,
  parameter int CS_LEN = adc_scan_pkg::CS_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        run,
  input  logic [2:0]  ch,
  input  logic        din,
  output logic [5:0]  bit_cnt,
  output logic        csn,
  output logic        dout,
  output logic        done,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data
);
  import adc_scan_pkg::*;
  logic [7:0] ctrl;
  logic [10:0] sh;
  logic [2:0] ch_q;
  logic xfer, last;
  assign xfer = run && bit_cnt < 6'(CS_LEN);
  assign last = run && bit_cnt == 6'(CS_LEN - 1);
  assign done = run && bit_cnt == 6'(FRAME_LEN - 1);
  assign ctrl = ctrl_byte(ch_q);
  assign csn = ~xfer;
  assign dout = run && bit_cnt < 6'd8 ? ctrl[~bit_cnt[2:0]] : 1'b0;
  // The final data bit is taken straight from din so the result is ready on the first GAP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      ch_q <= '0;
      sh <= '0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_data <= '0;
    end else begin
      bit_cnt <= clr ? '0 : run ? bit_cnt + 6'd1 : bit_cnt;
      if (clr) ch_q <= ch;
      if (xfer && bit_cnt >= 6'd4) sh <= {sh[9:0], din};
      res_valid <= last;
      if (last) begin
        res_ch <= ch_q;
        res_data <= {sh, din};
      end
    end
  end
endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel ADC scan sequencer with single-shot and periodic auto scanning
//   fab_clk_8MHz/rst : clock, synchronous active-high reset
//   start, auto_en   : single-scan request, periodic scan enable
//   ch_mask, period  : enabled channels, idle clocks between auto scans
//   sense_*          : ADC serial interface (csn, sclk gate, dout to ADC, din from ADC)
//   busy, scan_done, overrun : scan status strobes
//   res_valid/res_ch/res_data: per-channel conversion result
module adc_scan_ctrl #(
  parameter int N_CH = adc_scan_pkg::N_CH,
  parameter int FRAME_LEN = adc_scan_pkg::FRAME_LEN,
  parameter int CS_LEN = adc_scan_pkg::CS_LEN
) (
  input  logic            fab_clk_8MHz,
  input  logic            rst,
  input  logic            start,
  input  logic            auto_en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [31:0]     period,
  output logic            sense_csn,
  output logic            sense_sclk_en,
  output logic            sense_dout,
  input  logic            sense_din,
  output logic            busy,
  output logic            res_valid,
  output logic [2:0]      res_ch,
  output logic [11:0]     res_data,
  output logic            scan_done,
  output logic            overrun
);
  import adc_scan_pkg::*;
  state_t state, state_nxt;
  logic [N_CH-1:0] mask_q, mask_nxt;
  logic [31:0] wait_cnt;
  logic [5:0] bit_cnt;
  logic [2:0] sel;
  logic done, wait_more;
  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (mask_q[i]) sel = 3'(i);
  end
  // WAIT lasts max(period, 1) cycles: the exit decision looks one count ahead.
  assign wait_more = {1'b0, wait_cnt} + 33'd1 < {1'b0, period};
  assign busy = state inside {SETUP, XFER, GAP};
  assign sense_sclk_en = ~sense_csn;
  always_comb begin
    state_nxt = state;
    mask_nxt = mask_q;
    case (state)
      IDLE: if (start || auto_en) begin
        state_nxt = SETUP;
        mask_nxt = ch_mask;
      end
      SETUP: begin
        state_nxt = mask_q == '0 ? (auto_en ? WAIT : IDLE) : XFER;
        mask_nxt = mask_q & (mask_q - N_CH'(1));
      end
      XFER: if (bit_cnt == 6'(CS_LEN - 1)) state_nxt = GAP;
      GAP: if (done) state_nxt = SETUP;
      WAIT: if (start || (auto_en && !wait_more)) begin
        state_nxt = SETUP;
        mask_nxt = ch_mask;
      end else if (!auto_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge fab_clk_8MHz) begin
    if (rst) begin
      state <= IDLE;
      mask_q <= '0;
      wait_cnt <= '0;
      scan_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      mask_q <= mask_nxt;
      wait_cnt <= state == WAIT && state_nxt == WAIT ? wait_cnt + 32'd1 : '0;
      scan_done <= state == SETUP && mask_q == '0;
      overrun <= start && busy;
    end
  end
  adc_spi_frame #(.FRAME_LEN(FRAME_LEN), .CS_LEN(CS_LEN)) u_frame (
    .clk(fab_clk_8MHz),
    .rst(rst),
    .clr(state == SETUP),
    .run(state == XFER || state == GAP),
    .ch(sel),
    .din(sense_din),
    .bit_cnt(bit_cnt),
    .csn(sense_csn),
    .dout(sense_dout),
    .done(done),
    .res_valid(res_valid),
    .res_ch(res_ch),
    .res_data(res_data)
  );
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: directed self-checking bench with an ADC serial model for adc_scan_ctrl
module tb_adc_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, auto_en = 1'b0, sense_din = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [31:0] period = '0;
  logic sense_csn, sense_sclk_en, sense_dout, busy, res_valid, scan_done, overrun;
  logic [2:0] res_ch;
  logic [11:0] res_data;
  int n_chk = 0, n_err = 0, cyc = 0, lowcnt = 0, n_low = 0, n_dbad = 0, n_gbad = 0, n_ov = 0;
  logic [7:0] dcap = '0;
  logic [11:0] adc_word = '0;
  int rv_cyc[$], sd_cyc[$];
  logic [2:0] rv_ch[$];
  logic [11:0] rv_dat[$];
  logic rv_busy[$];
  adc_scan_ctrl dut (
    .fab_clk_8MHz(clk), .rst(rst), .start(start), .auto_en(auto_en), .ch_mask(ch_mask),
    .period(period), .sense_csn(sense_csn), .sense_sclk_en(sense_sclk_en),
    .sense_dout(sense_dout), .sense_din(sense_din), .busy(busy), .res_valid(res_valid),
    .res_ch(res_ch), .res_data(res_data), .scan_done(scan_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ADC model and event log, both evaluated mid-cycle
  always @(negedge clk) begin
    if (!sense_csn) begin
      sense_din = (lowcnt >= 4 && lowcnt <= 15) ? adc_word[15 - lowcnt] : 1'b0;
      if (lowcnt < 8) dcap = {dcap[6:0], sense_dout};
      lowcnt++;
      n_low++;
    end else begin
      sense_din = 1'b0;
      lowcnt = 0;
    end
    if (sense_csn && sense_dout) n_dbad++;
    if (sense_sclk_en === sense_csn) n_gbad++;
    if (res_valid) begin
      rv_cyc.push_back(cyc);
      rv_ch.push_back(res_ch);
      rv_dat.push_back(res_data);
      rv_busy.push_back(busy);
    end
    if (scan_done) sd_cyc.push_back(cyc);
    if (overrun) n_ov++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start(output int st);
    @(negedge clk);
    start = 1'b1;
    st = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    int st, st2, b, s, l, o, k;
    bit hit;
    tick(3);
    chk("rst_csn", sense_csn, 1);
    chk("rst_sclk", sense_sclk_en, 0);
    chk("rst_dout", sense_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_data", res_data, 0);
    chk("rst_sd", scan_done, 0);
    chk("rst_ov", overrun, 0);
    rst = 1'b0;
    tick(2);
    // single channel 2
    ch_mask = 8'h04; adc_word = 12'hA5C;
    b = rv_cyc.size(); s = sd_cyc.size(); l = n_low;
    pulse_start(st);
    tick(90);
    chk("one_csn_low", n_low - l, 16);
    chk("one_dout", dcap, 8'hD7);
    chk("one_nrv", rv_cyc.size() - b, 1);
    chk("one_ch", rv_ch[b], 2);
    chk("one_data", rv_dat[b], 12'hA5C);
    chk("one_nsd", sd_cyc.size() - s, 1);
    chk("one_sd_lag", sd_cyc[s] - rv_cyc[b], 36);
    chk("one_hold", res_data, 12'hA5C);
    chk("one_idle_busy", busy, 0);
    // channels 0 and 7, mask changed mid-scan
    ch_mask = 8'h81; adc_word = 12'h3C7;
    b = rv_cyc.size(); s = sd_cyc.size(); l = n_low;
    pulse_start(st);
    ch_mask = 8'h02;
    tick(150);
    chk("two_nrv", rv_cyc.size() - b, 2);
    chk("two_ch0", rv_ch[b], 0);
    chk("two_ch1", rv_ch[b+1], 7);
    chk("two_gap", rv_cyc[b+1] - rv_cyc[b], 52);
    chk("two_busy", rv_busy[b] && rv_busy[b+1], 1);
    chk("two_nsd", sd_cyc.size() - s, 1);
    chk("two_data", rv_dat[b+1], 12'h3C7);
    chk("two_csn_low", n_low - l, 32);
    // empty mask
    ch_mask = 8'h00;
    b = rv_cyc.size(); s = sd_cyc.size(); l = n_low;
    pulse_start(st);
    tick(10);
    chk("empty_nsd", sd_cyc.size() - s, 1);
    chk("empty_lag", sd_cyc[s] - st, 2);
    chk("empty_csn_low", n_low - l, 0);
    chk("empty_nrv", rv_cyc.size() - b, 0);
    // auto scan, period 100
    ch_mask = 8'h01; period = 100;
    b = rv_cyc.size();
    @(negedge clk);
    auto_en = 1'b1;
    for (int i = 0; i < 700 && rv_cyc.size() < b + 3; i++) @(negedge clk);
    auto_en = 1'b0;
    chk("auto_got3", rv_cyc.size() - b, 3);
    chk("auto_gap1", rv_cyc[b+1] - rv_cyc[b], 153);
    chk("auto_gap2", rv_cyc[b+2] - rv_cyc[b+1], 153);
    b = rv_cyc.size(); s = sd_cyc.size();
    tick(250);
    chk("auto_off_nrv", rv_cyc.size() - b, 0);
    chk("auto_off_nsd", sd_cyc.size() - s, 1);
    chk("auto_off_busy", busy, 0);
    // auto scan, period 0
    period = 0;
    b = rv_cyc.size();
    @(negedge clk);
    auto_en = 1'b1;
    for (int i = 0; i < 300 && rv_cyc.size() < b + 2; i++) @(negedge clk);
    auto_en = 1'b0;
    chk("p0_gap", rv_cyc[b+1] - rv_cyc[b], 54);
    tick(100);
    // start while busy
    ch_mask = 8'h04; adc_word = 12'h5A3;
    b = rv_cyc.size(); l = n_low; o = n_ov;
    pulse_start(st);
    tick(5);
    pulse_start(st2);
    tick(90);
    chk("ovr_count", n_ov - o, 1);
    chk("ovr_nrv", rv_cyc.size() - b, 1);
    chk("ovr_data", rv_dat[b], 12'h5A3);
    chk("ovr_csn_low", n_low - l, 16);
    // reset in the middle of a transfer
    b = rv_cyc.size();
    k = 0; hit = 1'b0;
    pulse_start(st);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (!sense_csn) begin
        if (k == 9) begin
          rst = 1'b1;
          hit = 1'b1;
        end
        k++;
      end
    end
    chk("abort_hit", hit, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_csn", sense_csn, 1);
    chk("abort_sclk", sense_sclk_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", res_data, 0);
    tick(80);
    chk("abort_nrv", rv_cyc.size() - b, 0);
    adc_word = 12'h0F1;
    b = rv_cyc.size();
    pulse_start(st);
    tick(90);
    chk("after_nrv", rv_cyc.size() - b, 1);
    chk("after_ch", rv_ch[b], 2);
    chk("after_data", rv_dat[b], 12'h0F1);
    chk("dout_idle", n_dbad, 0);
    chk("sclk_gate", n_gbad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameters SHALL be: N_CH, default 8, number of ADC channels; FRAME_LEN, default 51, clocks per channel frame; CS_LEN, default 16, clocks with chip-select low.
REQ-002 fab_clk_8MHz  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request for a single scan.
REQ-005 auto_en  in  1  level; repeat scans every period clocks.
REQ-006 ch_mask  in  8  channel enable, bit n enables channel n.
REQ-007 period  in  32  idle clocks between auto scans.
REQ-008 sense_csn  out  1  ADC chip select, active low.
REQ-009 sense_sclk_en  out  1  serial-clock gate; equals ~sense_csn.
REQ-010 sense_dout  out  1  control-bit stream to the ADC.
REQ-011 sense_din  in  1  conversion-bit stream from the ADC.
REQ-012 busy  out  1  high from scan start to scan_done.
REQ-013 res_valid  out  1  one-cycle result strobe.
REQ-014 res_ch  out  3  channel of the current result.
REQ-015 res_data  out  12  conversion result, unsigned.
REQ-016 scan_done  out  1  one-cycle end-of-scan strobe.
REQ-017 overrun  out  1  one-cycle strobe when start is ignored because busy is high.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, XFER, GAP, WAIT.
REQ-019 In IDLE, start=1 or auto_en=1 SHALL latch ch_mask into mask_q, set busy, and enter SETUP on the next cycle.
REQ-020 SETUP SHALL select the lowest set bit of mask_q, clear that bit, and enter XFER with bit_cnt=0; if mask_q is zero, it SHALL pulse scan_done and enter WAIT if auto_en=1, otherwise IDLE.
REQ-021 During XFER (bit_cnt 0..CS_LEN-1), sense_csn SHALL be 0; at bit_cnt=CS_LEN-1 the FSM SHALL enter GAP.
REQ-022 The control byte SHALL be {2'b11, ch[2:0], 3'b111}, driven MSB-first on sense_dout at bit_cnt 0..7; sense_dout SHALL be 0 otherwise.
REQ-023 sense_din SHALL be sampled at bit_cnt 4..15, MSB-first, into a 12-bit shift register.
REQ-024 On the first GAP cycle (bit_cnt=CS_LEN), res_valid SHALL be 1 with res_ch and res_data held until the next result.
REQ-025 GAP SHALL keep sense_csn=1 until bit_cnt=FRAME_LEN-1, then return to SETUP, giving 1+FRAME_LEN clocks per enabled channel.
REQ-026 WAIT SHALL count period clocks, then enter SETUP with mask_q reloaded from ch_mask.
- busy SHALL be 0 in WAIT.
- auto_en=0 in WAIT SHALL return the FSM to IDLE next cycle.
- period=0 SHALL give back-to-back scans, with exactly one WAIT cycle.
REQ-027 start while busy=1 SHALL be ignored and pulse overrun; start in WAIT SHALL begin a scan immediately.
REQ-028 Clearing auto_en mid-scan SHALL complete the current scan, then enter IDLE.
REQ-029 ch_mask changes mid-scan SHALL NOT affect the current scan.
REQ-030 bit_cnt SHALL be 6 bits and saturate-free, cleared on each SETUP.
REQ-031 The period counter SHALL be 32 bits, compared with <.

Reset
REQ-032 While rst=1, outputs at the next edge SHALL be: sense_csn=1, sense_sclk_en=0, sense_dout=0, busy=0, res_valid=0, res_ch=0, res_data=0, scan_done=0, overrun=0.
- State SHALL be IDLE, mask_q=0, and all counters 0.
REQ-033 Reset asserted mid-XFER SHALL deassert sense_csn on the next edge and emit no res_valid for the aborted frame.

Structure
REQ-034 Package adc_scan_pkg SHALL hold:
- the state enum;
- N_CH, FRAME_LEN, CS_LEN;
- CTRL_PREFIX=2'b11, CTRL_SUFFIX=3'b111.
REQ-035 Sub-module adc_spi_frame SHALL implement one frame (bit_cnt, csn, dout, din shift, done), sequenced by adc_scan_ctrl.

Verification
REQ-036 ch_mask=8'h04, start pulse, ADC model returns 12'hA5C -> csn low 16 clocks, dout=8'b11010111, res_valid once with res_ch=2 and res_data=12'hA5C, then scan_done.
REQ-037 ch_mask=8'h81, start -> results for ch 0 then ch 7, 52 clocks apart, then one scan_done; busy spans both frames.
REQ-038 ch_mask=0, start -> scan_done exactly 2 clocks after start, csn never low.
REQ-039 auto_en=1, period=100, ch_mask=8'h01 -> successive res_valid exactly 52+1+100 clocks apart, so one WAIT entry plus the count.
REQ-040 start during XFER -> overrun=1 for one cycle, and the frame sequence is unchanged.
REQ-041 rst at bit_cnt=9 -> csn=1 next clock, no res_valid, FSM in IDLE, and a following start scans normally.
